// File: rtl/neighbor_gatherer.sv
// neighbor_gatherer: snapshots a ROWS x COLS cellular board and streams every
// cell in raster order with its 8-neighbour bitmap, using a valid/ready handshake.
// Optional feature: define TORUS_EN to wrap neighbour coordinates (toroidal board);
// without it, neighbours outside the board read as 0.
module neighbor_gatherer #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ROWS*COLS-1:0]      cells_in,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                neighbors,
  output logic                      center,
  output logic [$clog2(ROWS)-1:0]   row,
  output logic [$clog2(COLS)-1:0]   col,
  output logic                      out_last,
  output logic                      done
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned NC = ROWS * COLS;
  localparam int unsigned IW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [NC-1:0]   snap;

  logic [NC-1:0]   src_board;
  logic [RW-1:0]   nxt_row;
  logic [CW-1:0]   nxt_col;
  logic            nxt_last;
  logic [7:0]      nxt_nb;
  logic            nxt_ctr;

  // Next cell to present: (0,0) from the live input when starting, else the raster successor from the snapshot
  always_comb begin
    src_board = snap;
    nxt_row   = row;
    nxt_col   = col;
    if (state == IDLE) begin
      src_board = cells_in;
      nxt_row   = '0;
      nxt_col   = '0;
    end else if (col == CW'(COLS - 1)) begin
      nxt_col = '0;
      nxt_row = row + RW'(1);
    end else begin
      nxt_col = col + CW'(1);
    end
    nxt_last = (nxt_row == RW'(ROWS - 1)) && (nxt_col == CW'(COLS - 1));
  end

  // Gather the centre bit and the 8 neighbours of the next cell (bit order NW,N,NE,W,E,SW,S,SE)
  always_comb begin
    int  nr;
    int  nc;
    int  dr;
    int  dc;
    logic inb;
    nxt_nb  = '0;
    nr      = 0;
    nc      = 0;
    dr      = 0;
    dc      = 0;
    inb     = 1'b0;
    nxt_ctr = src_board[IW'(int'(nxt_row) * int'(COLS) + int'(nxt_col))];
    for (int k = 0; k < 8; k++) begin
      dr = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
      case (k)
        0, 3, 5: dc = -1;
        1, 6:    dc = 0;
        default: dc = 1;
      endcase
      nr = int'(nxt_row) + dr;
      nc = int'(nxt_col) + dc;
`ifdef TORUS_EN
      if (nr < 0)               nr = nr + int'(ROWS);
      else if (nr >= int'(ROWS)) nr = nr - int'(ROWS);
      if (nc < 0)               nc = nc + int'(COLS);
      else if (nc >= int'(COLS)) nc = nc - int'(COLS);
      inb = 1'b1;
`else
      inb = (nr >= 0) && (nr < int'(ROWS)) && (nc >= 0) && (nc < int'(COLS));
`endif
      if (inb) begin
        nxt_nb[3'(k)] = src_board[IW'(nr * int'(COLS) + nc)];
      end
    end
  end

  // Scan FSM with registered beat outputs; a beat advances only when accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      snap      <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      neighbors <= '0;
      center    <= 1'b0;
      row       <= '0;
      col       <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          if (start) begin
            snap      <= cells_in;
            row       <= nxt_row;
            col       <= nxt_col;
            neighbors <= nxt_nb;
            center    <= nxt_ctr;
            out_last  <= nxt_last;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              row       <= nxt_row;
              col       <= nxt_col;
              neighbors <= nxt_nb;
              center    <= nxt_ctr;
              out_last  <= nxt_last;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          out_last  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neighbor_gatherer.sv
// Directed bench for neighbor_gatherer on the default 8x8 board.
module tb_neighbor_gatherer;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] cells_in;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  neighbors;
  logic        center;
  logic [2:0]  row;
  logic [2:0]  col;
  logic        out_last;
  logic        done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  neighbor_gatherer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cells_in  (cells_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .neighbors (neighbors),
    .center    (center),
    .row       (row),
    .col       (col),
    .out_last  (out_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles in which done is high
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand-derived neighbour bitmaps: t=0 empty board, t=1 only (3,3), t=2 only (0,0)
  function automatic logic [7:0] exp_nb(input int t, input int r, input int c);
    logic [7:0] v;
    v = 8'h00;
    if (t == 1) begin
      if (r == 2 && c == 2) v = 8'h80;
      if (r == 2 && c == 3) v = 8'h40;
      if (r == 2 && c == 4) v = 8'h20;
      if (r == 3 && c == 2) v = 8'h10;
      if (r == 3 && c == 4) v = 8'h08;
      if (r == 4 && c == 2) v = 8'h04;
      if (r == 4 && c == 3) v = 8'h02;
      if (r == 4 && c == 4) v = 8'h01;
    end else if (t == 2) begin
      if (r == 0 && c == 1) v = 8'h08;
      if (r == 1 && c == 0) v = 8'h02;
      if (r == 1 && c == 1) v = 8'h01;
`ifdef TORUS_EN
      if (r == 0 && c == 7) v = 8'h10;
      if (r == 1 && c == 7) v = 8'h04;
      if (r == 7 && c == 0) v = 8'h40;
      if (r == 7 && c == 1) v = 8'h20;
      if (r == 7 && c == 7) v = 8'h80;
`endif
    end
    return v;
  endfunction

  // One scan: optional 5-cycle stall, optional reset abort, optional start/cells_in noise
  task automatic do_scan(input int t, input logic [63:0] board, input int stall_at,
                         input int abort_at, input bit noise);
    int d0;
    int r;
    int c;
    logic [13:0] hold;
    d0 = done_cnt;
    @(negedge clk);
    cells_in  = board;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_first", busy, 1);
    for (int k = 0; k < ROWS * COLS; k++) begin
      r = k / COLS;
      c = k % COLS;
      check($sformatf("pos k%0d", k), {row, col}, r * COLS + c);
      check($sformatf("valid k%0d", k), out_valid, 1);
      check($sformatf("nb (%0d,%0d)", r, c), neighbors, exp_nb(t, r, c));
      check($sformatf("center (%0d,%0d)", r, c), center, board[r * COLS + c]);
      check($sformatf("last k%0d", k), out_last, (k == ROWS * COLS - 1) ? 1 : 0);
      if (k == abort_at) begin
        rst = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pos", {row, col}, 0);
        check("rst_nb", {neighbors, center, out_last, done}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle", {out_valid, busy}, 0);
        check("abort_no_done", done_cnt - d0, 0);
        return;
      end
      if (k == stall_at) begin
        out_ready = 1'b0;
        hold = {row, col, neighbors};
        repeat (5) begin
          @(negedge clk);
          check("stall_hold", {row, col, neighbors, out_valid}, {hold, 1'b1});
        end
        out_ready = 1'b1;
      end
      if (noise) begin
        start    = 1'($urandom % 2);
        cells_in = {$urandom, $urandom};
      end
      @(negedge clk);
    end
    check("done_pulse", {done, out_valid, busy, out_last}, 4'b1010);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_done", {done, out_valid, busy}, 0);
    check("done_count", done_cnt - d0, 1);
    @(negedge clk);
    check("start_in_done_ignored", out_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    cells_in  = '0;
    #1 rst = 1'b0;
    #2;
    check("reset_outputs", {busy, out_valid, neighbors, center, row, col, out_last, done}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_wait", {busy, out_valid, done}, 0);

    do_scan(0, 64'h0, -1, -1, 1'b0);
    do_scan(1, 64'h1 << 27, 1, -1, 1'b0);
    do_scan(2, 64'h1, -1, -1, 1'b0);
    do_scan(1, 64'h1 << 27, -1, -1, 1'b1);
    do_scan(1, 64'h1 << 27, -1, 21, 1'b0);
    do_scan(2, 64'h1, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neighbor_gatherer.md
NEIGHBOR_GATHERER -- requirements
Module: neighbor_gatherer

Interface
REQ-001 Parameter: ROWS, default 8, number of board rows (row 0 = top).
REQ-002 Parameter: COLS, default 8, number of board columns (col 0 = left).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  begin a scan; sampled only in IDLE.
REQ-006 cells_in  input  ROWS*COLS  board state; bit r*COLS+c = cell (r,c), 1 = alive.
REQ-007 busy  output  1  high in SCAN and DONE.
REQ-008 out_valid  output  1  neighbors/center/row/col/out_last valid.
REQ-009 out_ready  input  1  consumer accepts the current beat.
REQ-010 neighbors  output  8  bit0 NW, 1 N, 2 NE, 3 W, 4 E, 5 SW, 6 S, 7 SE of current cell.
REQ-011 center  output  1  state of current cell.
REQ-012 row  output  $clog2(ROWS)  current cell row.
REQ-013 col  output  $clog2(COLS)  current cell column.
REQ-014 out_last  output  1  current beat is cell (ROWS-1,COLS-1).
REQ-015 done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-016 States SHALL be IDLE, SCAN and DONE.
REQ-017 In IDLE with start=1 at a rising edge, the block SHALL copy cells_in into an internal snapshot, set row=col=0, and enter SCAN.
REQ-018 All outputs SHALL be derived from the snapshot; changes to cells_in during SCAN SHALL have no effect.
REQ-019 out_valid SHALL be 1 in SCAN and 0 in IDLE and DONE; the first beat appears the cycle after start is sampled.
REQ-020 A beat transfers on a rising edge with out_valid=1 and out_ready=1; one beat per cycle max.
REQ-021 While out_valid=1 and out_ready=0, all beat outputs SHALL remain stable.
REQ-022 Cells SHALL be emitted in raster order: col increments, wraps to 0 at COLS-1 and row increments.
REQ-023 On transfer of the beat with out_last=1, the FSM SHALL enter DONE; done=1 for exactly that one cycle; then IDLE.
REQ-024 start SHALL be ignored in SCAN and DONE; it is honoured again from the first IDLE cycle.
REQ-025 Neighbor positions outside the board SHALL follow REQ-031/REQ-032.
REQ-026 A full scan with out_ready held high SHALL take exactly ROWS*COLS beat cycles plus one DONE cycle.

Reset
REQ-027 Asserting rst SHALL immediately force IDLE, out_valid=0, busy=0, done=0, out_last=0, row=0, col=0, neighbors=0, center=0.
REQ-028 Snapshot contents after reset SHALL be 0.
REQ-029 Reset mid-scan SHALL abandon the scan; no done pulse is produced.
REQ-030 After rst deasserts, the block SHALL wait in IDLE for start.

Configuration
REQ-031 Macro TORUS_EN defined: row and column indices SHALL wrap modulo ROWS/COLS (toroidal board).
REQ-032 TORUS_EN undefined: out-of-board neighbor bits SHALL read 0; all other behaviour identical.

Verification
REQ-033 All-zero board, start, out_ready=1: 64 beats, all neighbors=8'h00, center=0; out_last only on (7,7); done one cycle after it.
REQ-034 Only (3,3) alive: (2,2)->8'h80, (2,3)->8'h40, (3,4)->8'h08, (4,4)->8'h01, (3,3)->8'h00 with center=1; all other cells 8'h00.
REQ-035 Backpressure: out_ready=0 for 5 cycles at beat (0,1) -> row/col/neighbors held for all 5 cycles; (0,2) follows the cycle after out_ready returns to 1.
REQ-036 Only (0,0) alive: with TORUS_EN, (7,7)->8'h80 and (0,7)->8'h10; without TORUS_EN, both give 8'h00.
REQ-037 rst low at beat (2,5) -> out_valid=0 and busy=0 with no clock edge; no done; a new start scans from (0,0).
REQ-038 start pulses and cells_in toggling during SCAN -> no restart, beats unchanged, one done pulse only.
